ntt_stream_ctrl: RTL and testbench

//  Stream-side sequencer in front of ntt_engine: accepts N coefficients on a valid/ready

---
 rtl/ntt_pkg.sv | 23 ++
 rtl/ntt_mod_reduce1.sv | 24 ++
 rtl/ntt_stream_ctrl.sv | 152 +++++++++++++++
 tb/tb_ntt_stream_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants, sequencer states and index bit-reversal for the NTT stream path
package ntt_pkg;

  localparam int N_LOG = 3;
  localparam int N     = 1 << N_LOG;
  localparam int Q     = 17;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    KICK  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic logic [N_LOG-1:0] bitrev(input logic [N_LOG-1:0] i_idx);
    logic [N_LOG-1:0] w_rev;
    for (int b = 0; b < N_LOG; b++) begin
      w_rev[b] = i_idx[N_LOG-1-b];
    end
    return w_rev;
  endfunction

endpackage

// File: rtl/ntt_mod_reduce1.sv
// rtl/ntt_mod_reduce1.sv - single conditional subtract into [0,Q), flags inputs at or above 2Q
module ntt_mod_reduce1 #(
  parameter int Q = 17
) (
  input  logic [63:0] i_data,
  output logic [63:0] o_data,
  output logic        o_range_err
);

  localparam logic [63:0] W_Q1 = 64'(Q);
  localparam logic [63:0] W_Q2 = 64'(2 * Q);

  always_comb begin
    o_range_err = (i_data >= W_Q2);
    if (i_data < W_Q1) begin
      o_data = i_data;
    end else if (!o_range_err) begin
      o_data = i_data - W_Q1;
    end else begin
      o_data = '0;
    end
  end

endmodule

// File: rtl/ntt_stream_ctrl.sv
// rtl/ntt_stream_ctrl.sv - loads N reduced coefficients into the engine, kicks it, drains results in order
module ntt_stream_ctrl #(
  parameter int N_LOG   = 3,
  parameter int N       = 8,
  parameter int Q       = 17,
  parameter int BITREV  = 1,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [63:0]      s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [63:0]      m_data,
  output logic             m_last,
  output logic             busy,
  output logic             err,
  output logic             eng_start,
  input  logic             eng_done,
  output logic             eng_rw_mode,
  output logic [N_LOG-1:0] eng_rw_addr,
  output logic [63:0]      eng_rw_data_in,
  input  logic [63:0]      eng_rw_data_out
);

  import ntt_pkg::*;

  localparam int TW = $clog2(TIMEOUT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_LOG-1:0] r_wr_idx;
  logic [N_LOG-1:0] r_rd_idx;
  logic [TW-1:0]    r_tmo_cnt;
  logic             r_prime;
  logic             r_err;
  logic             r_live;
  logic [63:0]      w_red_data;
  logic             w_red_oor;
  logic             w_s_fire;
  logic             w_m_fire;
  logic             w_tmo_hit;

  ntt_mod_reduce1 #(.Q(Q)) u_reduce (
    .i_data      (s_data),
    .o_data      (w_red_data),
    .o_range_err (w_red_oor)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    s_ready        = 1'b0;
    eng_start      = 1'b0;
    eng_rw_mode    = 1'b0;
    eng_rw_addr    = '0;
    eng_rw_data_in = '0;
    busy           = 1'b0;
    w_s_fire       = 1'b0;
    w_m_fire       = 1'b0;
    w_tmo_hit      = 1'b0;
    case (r_state)
      LOAD: begin
        // r_live keeps s_ready low through the reset cycle itself
        s_ready  = r_live;
        w_s_fire = s_valid && r_live;
        if (w_s_fire) begin
          eng_rw_mode    = 1'b1;
          eng_rw_addr    = (BITREV != 0) ? bitrev(r_wr_idx) : r_wr_idx;
          eng_rw_data_in = w_red_data;
          if (r_wr_idx == N_LOG'(N - 1)) begin
            w_state_nxt = KICK;
          end
        end
      end
      KICK: begin
        busy        = 1'b1;
        eng_start   = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (eng_done) begin
          w_state_nxt = DRAIN;
        end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      DRAIN: begin
        busy        = 1'b1;
        eng_rw_addr = r_rd_idx;
        w_m_fire    = r_prime && m_ready;
        if (w_m_fire && (r_rd_idx == N_LOG'(N - 1))) begin
          w_state_nxt = LOAD;
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_live    <= 1'b0;
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      r_tmo_cnt <= '0;
      r_prime   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_s_fire) begin
        r_wr_idx <= r_wr_idx + 1'b1;
      end
      if ((w_s_fire && w_red_oor) || w_tmo_hit) begin
        r_err <= 1'b1;
      end
      if (r_state == KICK) begin
        r_tmo_cnt <= '0;
      end else if (r_state == RUN) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      // prime rises one cycle after the address settles, matching the engine's registered read
      if (r_state == RUN) begin
        r_rd_idx <= '0;
        r_prime  <= 1'b0;
      end else if (r_state == DRAIN) begin
        if (w_m_fire) begin
          r_rd_idx <= r_rd_idx + 1'b1;
          r_prime  <= 1'b0;
        end else begin
          r_prime <= 1'b1;
        end
      end
    end
  end

  assign m_valid = r_prime;
  assign m_data  = r_prime ? eng_rw_data_out : '0;
  assign m_last  = r_prime && (r_rd_idx == N_LOG'(N - 1));
  assign err     = r_err;

endmodule

// File: tb/tb_ntt_stream_ctrl.sv
// tb/tb_ntt_stream_ctrl.sv - random frames through the sequencer with a behavioural engine and NTT model
module tb_ntt_stream_ctrl;

  typedef longint vec_t [8];

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_last;
  logic        busy;
  logic        err;
  logic        eng_start;
  logic        eng_done;
  logic        eng_rw_mode;
  logic [2:0]  eng_rw_addr;
  logic [63:0] eng_rw_data_in;
  logic [63:0] eng_rw_data_out;

  ntt_stream_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_last          (m_last),
    .busy            (busy),
    .err             (err),
    .eng_start       (eng_start),
    .eng_done        (eng_done),
    .eng_rw_mode     (eng_rw_mode),
    .eng_rw_addr     (eng_rw_addr),
    .eng_rw_data_in  (eng_rw_data_in),
    .eng_rw_data_out (eng_rw_data_out)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          load_cnt = 0;
  int          frame_outs = 0;
  int          frames_done = 0;
  int          exp_start_cyc = -1;
  int          tmo_due = -1;
  int          hold_cnt = 0;
  int          eng_cnt = 0;
  bit          tmo_fired = 0;
  bit          hang = 0;
  bit          rnd_ready = 0;
  bit          prev_hold = 0;
  logic        rst_q = 0;
  logic        exp_err = 0;
  logic [63:0] prev_data = '0;
  longint      exp_q [$];
  vec_t        mdl_frame;
  logic [63:0] mem [8];
  logic [63:0] fr [8];
  logic [63:0] addr_log [8];
  logic [63:0] din_log [8];
  logic [63:0] out_log [8];
  longint      mdl_log [8];
  logic [2:0]  exp_addr [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
  longint      gold [8] = '{10, 15, 7, 13, 15, 11, 6, 16};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] rev3(input int i);
    logic [2:0] b;
    b = i[2:0];
    return {b[0], b[1], b[2]};
  endfunction

  function automatic logic [63:0] ref_reduce(input logic [63:0] v);
    if (v < 64'd17) return v;
    if (v < 64'd34) return v - 64'd17;
    return 64'd0;
  endfunction

  // X[k] = sum_j x[j] * 2^(j*k) mod 17; 2 has multiplicative order 8 mod 17
  function automatic longint dft_k(input vec_t x, input int k);
    longint acc, w, wk;
    acc = 0;
    w = 1;
    wk = 1;
    for (int i = 0; i < k; i++) wk = (wk * 2) % 17;
    for (int j = 0; j < 8; j++) begin
      acc = (acc + x[j] * w) % 17;
      w = (w * wk) % 17;
    end
    return acc;
  endfunction

  function automatic longint eng_k(input int k);
    vec_t t;
    for (int i = 0; i < 8; i++) t[i] = longint'(mem[rev3(i)]);
    return dft_k(t, k);
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) rst_q <= rst_n;

  // engine stand-in: bit-reversed input in, natural-order transform out, registered read port
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
  end
  always @(posedge clk) begin
    eng_rw_data_out <= mem[eng_rw_addr];
    if (eng_rw_mode) mem[eng_rw_addr] <= eng_rw_data_in;
    if (eng_start) begin
      eng_done <= 1'b0;
      eng_cnt  <= hang ? 0 : int'($urandom_range(2, 20));
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        for (int k = 0; k < 8; k++) mem[k] <= 64'(eng_k(k));
        eng_done <= 1'b1;
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt > 0) begin
        m_ready = 1'b0;
        hold_cnt--;
      end else begin
        m_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  initial begin
    longint e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_q) begin
        load_cnt = 0;
        exp_q.delete();
        exp_err = 0;
        exp_start_cyc = -1;
        tmo_due = -1;
        prev_hold = 0;
        frame_outs = 0;
      end else begin
        if (tmo_due == cyc) begin
          exp_err = 1;
          exp_q.delete();
          tmo_fired = 1;
          tmo_due = -1;
          chk("tmo_busy", 64'(busy), 0);
          chk("tmo_s_ready", 64'(s_ready), 1);
        end
        if (tmo_due == cyc + 1) chk("run_busy", 64'(busy), 1);
        chk("err", 64'(err), 64'(exp_err));
        chk("eng_start", 64'(eng_start), 64'(cyc == exp_start_cyc));
        if (eng_start && hang) tmo_due = cyc + 65;
        chk("rw_mode", 64'(eng_rw_mode), 64'(s_valid && s_ready));
        if (s_valid && s_ready) begin
          chk("wr_addr", 64'(eng_rw_addr), 64'(rev3(load_cnt)));
          chk("wr_data", eng_rw_data_in, ref_reduce(s_data));
          addr_log[load_cnt] = 64'(eng_rw_addr);
          din_log[load_cnt] = eng_rw_data_in;
          mdl_frame[load_cnt] = longint'(ref_reduce(s_data));
          if (s_data >= 64'd34) exp_err = 1;
          load_cnt++;
          if (load_cnt == 8) begin
            load_cnt = 0;
            exp_start_cyc = cyc + 1;
            for (int k = 0; k < 8; k++) begin
              e = dft_k(mdl_frame, k);
              exp_q.push_back(e);
              mdl_log[k] = e;
            end
          end
        end
        if (prev_hold) begin
          chk("hold_valid", 64'(m_valid), 1);
          chk("hold_data", m_data, prev_data);
        end
        if (m_valid && exp_q.size() == 0) begin
          chk("unexpected_valid", 64'(m_valid), 0);
        end else if (m_valid && m_ready) begin
          e = exp_q.pop_front();
          chk("m_data", m_data, 64'(e));
          chk("m_last", 64'(m_last), 64'(exp_q.size() == 0));
          out_log[frame_outs] = m_data;
          frame_outs++;
          if (exp_q.size() == 0) begin
            frame_outs = 0;
            frames_done++;
          end
        end
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
      end
    end
  end

  task automatic push(input logic [63:0] v);
    int t;
    bit acc;
    t = 0;
    s_valid = 1'b1;
    s_data = v;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 500);
    chk("push_accept", 64'(acc), 1);
    s_valid = 1'b0;
    s_data = {$urandom, $urandom};
  endtask

  task automatic send_frame(input bit gaps);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      push(fr[i]);
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 8; i++) fr[i] = 64'($urandom_range(0, 33));
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_done < n && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("frame_complete", 64'(frames_done), 64'(n));
  endtask

  task automatic wait_outs(input int n);
    int t;
    t = 0;
    while (frame_outs != n && t < 1000) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("outs_reached", 64'(frame_outs), 64'(n));
  endtask

  task automatic chk_zero_outs(input string nm);
    chk({nm, "_ctl"}, 64'({s_ready, m_valid, m_last, busy, err, eng_start, eng_rw_mode}), 0);
    chk({nm, "_m_data"}, m_data, 0);
    chk({nm, "_addr"}, 64'(eng_rw_addr), 0);
    chk({nm, "_din"}, eng_rw_data_in, 0);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk_zero_outs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("s_ready_after_rst", 64'(s_ready), 1);

    for (int i = 0; i < 8; i++) fr[i] = 64'(i);
    send_frame(0);
    wait_frames(1);
    for (int i = 0; i < 8; i++) chk("load_order", addr_log[i], 64'(exp_addr[i]));

    fr = '{64'd1, 64'd2, 64'd20, 64'd4, 64'd0, 64'd0, 64'd0, 64'd0};
    send_frame(0);
    wait_outs(3);
    hold_cnt = 5;
    repeat (5) @(negedge clk);
    #1;
    chk("hold_no_advance", 64'(frame_outs), 3);
    wait_frames(2);
    for (int i = 0; i < 8; i++) chk("golden_out", out_log[i], 64'(gold[i]));
    for (int i = 0; i < 8; i++) chk("golden_model", 64'(mdl_log[i]), 64'(gold[i]));
    chk("reduce_20", din_log[2], 3);
    chk("err_after_inrange", 64'(err), 0);

    rnd_ready = 1;
    fr = '{64'd16, 64'd17, 64'd33, 64'd34, 64'd40, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd0};
    send_frame(1);
    wait_frames(3);
    chk("err_after_40", 64'(err), 1);
    chk("reduce_17", din_log[1], 0);
    chk("reduce_33", din_log[2], 16);
    chk("reduce_40", din_log[4], 0);

    for (int f = 0; f < 3; f++) begin
      rand_frame();
      send_frame(1);
      wait_frames(4 + f);
    end
    chk("err_sticky", 64'(err), 1);

    rand_frame();
    send_frame(1);
    wait_outs(4);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_zero_outs("drain_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rand_frame();
    send_frame(1);
    wait_frames(7);

    hang = 1;
    rand_frame();
    send_frame(0);
    t = 0;
    while (!tmo_fired && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("timeout_seen", 64'(tmo_fired), 1);
    chk("err_after_timeout", 64'(err), 1);
    hang = 0;
    rand_frame();
    send_frame(1);
    wait_frames(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
